// File: rtl/sdram_window_responder.sv
// sdram_window_responder: Avalon-MM slave with programmable waitrequest latency over a preloadable word array
module sdram_window_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          slave_waitrequest,
  input  logic [31:0]   slave_address,
  input  logic          slave_read,
  output logic [31:0]   slave_readdata,
  input  logic          slave_write,
  input  logic [31:0]   slave_writedata,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [15:0]   read_count,
  output logic [15:0]   write_count,
  output logic          error
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [29:0] lat_word, sel_word;
  logic [31:0] lat_data;
  logic [3:0] cnt;
  logic lat_wr, req, sel_wr, sel_oor, lat_oor;
  assign req = slave_read | slave_write;
  assign sel_word = state == IDLE ? slave_address[31:2] : lat_word;
  assign sel_wr = state == IDLE ? slave_write : lat_wr;
  assign sel_oor = |sel_word[29:AW];
  assign lat_oor = |lat_word[29:AW];
  assign slave_waitrequest = state != ACCEPT;
  // Next state: IDLE samples a request, WAIT counts down or aborts on a dropped request, ACCEPT lasts one cycle
  always_comb begin
    state_n = state;
    if (state == IDLE && req) state_n = WAIT_CYCLES == 0 ? ACCEPT : WAIT;
    else if (state == WAIT) state_n = !req ? IDLE : cnt == 4'd1 ? ACCEPT : WAIT;
    else if (state == ACCEPT) state_n = IDLE;
  end
  // Request latch, wait counter, read capture on entry to ACCEPT, transfer counters and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lat_word <= '0;
      lat_data <= '0;
      lat_wr <= 1'b0;
      cnt <= '0;
      slave_readdata <= '0;
      read_count <= '0;
      write_count <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        lat_word <= slave_address[31:2];
        lat_data <= slave_writedata;
        lat_wr <= slave_write;
        if ((slave_read && slave_write) || |slave_address[1:0] || sel_oor) error <= 1'b1;
      end
      cnt <= state == IDLE ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
      if (state == WAIT && !req) error <= 1'b1;
      if (state_n == ACCEPT && !sel_wr) slave_readdata <= sel_oor ? 32'hDEADBEEF : mem[sel_word[AW-1:0]];
      if (state == ACCEPT) begin
        if (lat_wr) write_count <= write_count + 16'd1;
        else read_count <= read_count + 16'd1;
      end
    end
  end
  // Word array: preload first so a same-edge slave write to the same index wins; never cleared by reset
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (state == ACCEPT && lat_wr && !lat_oor) mem[lat_word[AW-1:0]] <= lat_data;
  end
endmodule

// File: tb/tb_sdram_window_responder.sv
// tb_sdram_window_responder: randomized check of two responders (WAIT_CYCLES 2 and 0) against a word-array model
module tb_sdram_window_responder;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic wreq[2], rd[2], wr[2], ld[2], err[2];
  logic [31:0] addr[2], wd[2], rdata[2], ldd[2];
  logic [9:0] lda[2];
  logic [15:0] rcnt[2], wcnt[2];
  logic [31:0] mref[2][DEPTH];
  logic [31:0] rdm[2];
  int rc[2], wc[2];
  bit e[2];
  int n = 0, nf = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_window_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
      .clk(clk), .reset(reset), .slave_waitrequest(wreq[g]), .slave_address(addr[g]),
      .slave_read(rd[g]), .slave_readdata(rdata[g]), .slave_write(wr[g]), .slave_writedata(wd[g]),
      .load_en(ld[g]), .load_addr(lda[g]), .load_data(ldd[g]),
      .read_count(rcnt[g]), .write_count(wcnt[g]), .error(err[g]));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic status(input int d);
    chk("waitrequest_idle", 32'(wreq[d]), 32'd1);
    chk("read_count", 32'(rcnt[d]), 32'(rc[d] % 65536));
    chk("write_count", 32'(wcnt[d]), 32'(wc[d] % 65536));
    chk("error", 32'(err[d]), 32'(e[d]));
  endtask
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a, input logic [31:0] data,
                        input bit b2b, input bit hold, input int pl_at, input logic [9:0] pa, input logic [31:0] pd);
    int wcy, k;
    bit oor;
    logic [9:0] idx;
    wcy = d == 0 ? 2 : 0;
    if (!b2b) chk("waitrequest_presented", 32'(wreq[d]), 32'd1);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = data;
    oor = a >= 32'(DEPTH * 4);
    idx = a[11:2];
    if ((r && w) || a[1:0] != 2'b0 || oor) e[d] = 1'b1;
    k = 0;
    for (int i = 1; i <= wcy + 3; i++) begin
      @(negedge clk);
      ld[d] = (i == pl_at); lda[d] = pa; ldd[d] = pd;
      if (!wreq[d]) begin
        k = i;
        break;
      end
    end
    chk("latency", 32'(k), 32'(wcy + 1 + int'(b2b)));
    if (pl_at > 0 && pl_at < wcy) mref[d][pa] = pd;
    if (!w) begin
      rdm[d] = oor ? 32'hDEADBEEF : mref[d][idx];
      chk("readdata", rdata[d], rdm[d]);
      rc[d]++;
    end
    if (pl_at > 0 && pl_at >= wcy) mref[d][pa] = pd;
    if (w) begin
      if (!oor) mref[d][idx] = data;
      wc[d]++;
    end
    if (!hold) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(negedge clk);
      ld[d] = 1'b0;
      status(d);
      chk("readdata_hold", rdata[d], rdm[d]);
    end
  endtask
  task automatic abort_read(input logic [31:0] a);
    rd[0] = 1'b1; addr[0] = a;
    if (a[1:0] != 2'b0 || a >= 32'(DEPTH * 4)) e[0] = 1'b1;
    @(negedge clk);
    chk("abort_waitrequest", 32'(wreq[0]), 32'd1);
    rd[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e[0] = 1'b1;
    status(0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      rc[d] = 0; wc[d] = 0; e[d] = 1'b0; rdm[d] = '0;
      chk("reset_readdata", rdata[d], 32'd0);
      status(d);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    int d, op, pl;
    logic [31:0] a, v;
    logic [9:0] pa;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; ld[i] = 0; addr[i] = '0; wd[i] = '0; lda[i] = '0; ldd[i] = '0;
    end
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < 2; j++) begin
        v = i < 4 ? (i == 0 ? 32'd1 : i == 1 ? 32'd5 : i == 2 ? 32'd3 : 32'd2) : $urandom;
        ld[j] = 1'b1; lda[j] = 10'(i); ldd[j] = v; mref[j][i] = v;
      end
      @(negedge clk);
    end
    ld[0] = 1'b0; ld[1] = 1'b0;
    for (int i = 0; i < 4; i++) access(0, 1, 0, 32'(i * 4), 0, 0, 0, 0, 0, 0);
    access(0, 0, 1, 32'h10, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    access(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    access(1, 1, 0, 32'h0, 0, 0, 1, 0, 0, 0);
    access(1, 1, 0, 32'h4, 0, 1, 0, 0, 0, 0);
    access(0, 1, 0, 32'h18, 0, 0, 0, 1, 10'd6, 32'h600DF00D);
    access(0, 0, 1, 32'h1C, 32'h12345678, 0, 0, 3, 10'd7, 32'h0BADCAFE);
    access(0, 1, 0, 32'h1C, 0, 0, 0, 0, 0, 0);
    access(1, 0, 1, 32'h24, 32'h13579BDF, 0, 0, 1, 10'd9, 32'h2468ACE0);
    access(1, 1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
    access(0, 1, 0, 32'h1000, 0, 0, 0, 0, 0, 0);
    access(0, 0, 1, 32'h1000, 32'hFFFF0000, 0, 0, 0, 0, 0);
    access(0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    abort_read(32'h8);
    access(0, 1, 1, 32'h14, 32'hCAFEBABE, 0, 0, 0, 0, 0);
    access(0, 1, 0, 32'h14, 0, 0, 0, 0, 0, 0);
    access(1, 1, 0, 32'h2A, 0, 0, 0, 0, 0, 0);
    wr[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hFEEDFACE;
    @(negedge clk);
    wr[0] = 1'b0;
    do_reset();
    access(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    for (int it = 0; it < 150; it++) begin
      d = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      a = $urandom_range(0, DEPTH - 1) * 4;
      if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 4095);
      pl = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, d == 0 ? 3 : 1)) : 0;
      pa = $urandom_range(0, 1) ? a[11:2] : 10'($urandom);
      if (op == 9 && d == 0) abort_read(a);
      else if (op < 5) access(d, 1, 0, a, 0, 0, 0, pl, pa, $urandom);
      else access(d, op == 8, 1, a, $urandom, 0, 0, pl, pa, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, nf);
    $finish;
  end
endmodule
